// File: rtl/dac_upd_pkg.sv
// dac_update_ctrl shared types: command opcodes, FSM states, data width.
// Optional watchdog is enabled by defining DAC_UPD_WATCHDOG_EN.
package dac_upd_pkg;

   localparam int DW = 16;

   typedef enum logic [1:0] {
      OP_FIXED = 2'b00,
      OP_RAMP  = 2'b01,
      OP_OFF   = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ARM  = 2'b01,
      S_RAMP = 2'b10,
      S_HOLD = 2'b11
   } state_e;

endpackage

// File: rtl/dac_upd_strobe_gen.sv
// Update-rate divider: one-cycle strobe on the last count and an
// apply pulse one cycle earlier so outputs settle before the strobe.
module dac_upd_strobe_gen #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int UPDATE_HZ = 300
) (
   input  logic clk,
   input  logic rst_l,
   output logic sync,
   output logic apply
);

   localparam int DIV = CLK_HZ / UPDATE_HZ;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] APT  = CW'(DIV - 2);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   assign sync  = (div_cnt == LAST);
   assign apply = (div_cnt == APT);

endmodule

// File: rtl/dac_update_ctrl.sv
// DAC command sequencer: latches host commands and applies them just
// before each update strobe. Define DAC_UPD_WATCHDOG_EN for the watchdog.
module dac_update_ctrl
   import dac_upd_pkg::*;
#(
   parameter int            CLK_HZ       = 50_000_000,
   parameter int            UPDATE_HZ    = 300,
   parameter int            RAMP_STROBES = 256,
   parameter logic [DW-1:0] RESET_VALUE  = 16'h0000,
   parameter int            WDOG_STROBES = 3000,
   parameter logic [DW-1:0] SAFE_VALUE   = 16'h0000
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_value,
   output logic          sync_300Hz,
   output logic          mode,
   output logic [DW-1:0] fixed_value,
   output logic          cs,
   output logic          busy,
   output logic          done,
   output logic          wdog_trip
);

   state_e        state, state_nxt, settled;
   op_e           lat_op;
   logic [DW-1:0] lat_val;
   logic [DW-1:0] ramp_cnt;
   logic          apply, accept, ramp_last, done_q, wd_fire;

   dac_upd_strobe_gen #(
      .CLK_HZ    (CLK_HZ),
      .UPDATE_HZ (UPDATE_HZ)
   ) u_strobe (
      .clk   (clk),
      .rst_l (rst_l),
      .sync  (sync_300Hz),
      .apply (apply)
   );

   assign accept    = cmd_valid & cmd_ready;
   assign ramp_last = sync_300Hz &
                      (ramp_cnt == DW'(RAMP_STROBES - 1));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_HOLD: begin
            if (accept) state_nxt = S_ARM;
         end
         S_ARM: begin
            if (apply) begin
               unique case (lat_op)
                  OP_FIXED: state_nxt = S_HOLD;
                  OP_RAMP:  state_nxt = S_RAMP;
                  OP_OFF:   state_nxt = S_IDLE;
                  OP_RSVD:  state_nxt = settled;
               endcase
            end
         end
         S_RAMP: begin
            if (ramp_last) state_nxt = S_HOLD;
         end
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = done_q;
      unique case (state)
         S_IDLE, S_HOLD: cmd_ready = 1'b1;
         S_ARM: begin
            busy = 1'b1;
            if (apply && lat_op == OP_RSVD) done = 1'b1;
         end
         S_RAMP: begin
            busy = 1'b1;
            if (ramp_last) done = 1'b1;
         end
      endcase
   end

   // settled remembers where a reserved op must return to
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lat_op  <= OP_FIXED;
         lat_val <= '0;
         settled <= S_IDLE;
      end else if (accept) begin
         lat_op  <= op_e'(cmd_op);
         lat_val <= cmd_value;
         settled <= state;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         ramp_cnt <= '0;
      end else if (state == S_ARM && apply) begin
         ramp_cnt <= '0;
      end else if (state == S_RAMP && sync_300Hz &&
                   ramp_cnt != '1) begin
         ramp_cnt <= ramp_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         mode        <= 1'b0;
         fixed_value <= RESET_VALUE;
         cs          <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == S_ARM && apply) begin
            unique case (lat_op)
               OP_FIXED: begin
                  mode        <= 1'b0;
                  fixed_value <= lat_val;
                  cs          <= 1'b1;
                  done_q      <= 1'b1;
               end
               OP_RAMP: begin
                  mode        <= 1'b1;
                  fixed_value <= lat_val;
                  cs          <= 1'b1;
               end
               OP_OFF: begin
                  mode        <= 1'b0;
                  fixed_value <= RESET_VALUE;
                  cs          <= 1'b0;
                  done_q      <= 1'b1;
               end
               OP_RSVD: begin
               end
            endcase
         end else if (wd_fire) begin
            mode        <= 1'b0;
            fixed_value <= SAFE_VALUE;
         end
      end
   end

`ifdef DAC_UPD_WATCHDOG_EN
   logic [DW-1:0] wd_cnt;
   logic          wd_trip_q;

   assign wd_fire = (state == S_HOLD) & apply & ~accept &
                    ~wd_trip_q &
                    (wd_cnt >= DW'(WDOG_STROBES));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wd_cnt    <= '0;
         wd_trip_q <= 1'b0;
      end else begin
         if (state != S_HOLD) begin
            wd_cnt <= '0;
         end else if (sync_300Hz && wd_cnt != '1) begin
            wd_cnt <= wd_cnt + DW'(1);
         end
         if (accept) begin
            wd_trip_q <= 1'b0;
         end else if (wd_fire) begin
            wd_trip_q <= 1'b1;
         end
      end
   end

   assign wdog_trip = wd_trip_q;
`else
   logic unused_wdog;

   assign unused_wdog = ^{32'(WDOG_STROBES), SAFE_VALUE};
   assign wd_fire     = 1'b0;
   assign wdog_trip   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_update_ctrl.sv
// Randomized self-checking bench for dac_update_ctrl (DIV=10).
// Exercises the watchdog path when DAC_UPD_WATCHDOG_EN is defined.
module tb_dac_update_ctrl;

   localparam int CLK_HZ    = 3000;
   localparam int UPDATE_HZ = 300;
   localparam int RAMP_N    = 4;
   localparam int WDOG_N    = 5;
   localparam int DIVT      = CLK_HZ / UPDATE_HZ;
   localparam logic [15:0] RST_V  = 16'h0000;
   localparam logic [15:0] SAFE_V = 16'h0000;
`ifdef DAC_UPD_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] cmd_value = 16'h0;
   logic        cmd_ready, sync_300Hz, mode, cs;
   logic        busy, done, wdog_trip;
   logic [15:0] fixed_value;
   logic [22:0] obs, exp_v;

   int checks = 0;
   int errors = 0;
   int cyc;

   logic        e_mode, e_cs;
   logic [15:0] e_val;
   int          acc_cyc, settle_cyc;

   dac_update_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .UPDATE_HZ    (UPDATE_HZ),
      .RAMP_STROBES (RAMP_N),
      .RESET_VALUE  (RST_V),
      .WDOG_STROBES (WDOG_N),
      .SAFE_VALUE   (SAFE_V)
   ) dut (
      .clk         (clk),
      .rst_l       (rst_l),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_value   (cmd_value),
      .sync_300Hz  (sync_300Hz),
      .mode        (mode),
      .fixed_value (fixed_value),
      .cs          (cs),
      .busy        (busy),
      .done        (done),
      .wdog_trip   (wdog_trip)
   );

   always #5 clk = ~clk;

   // cycle index since reset release; cycle n has div_cnt = n mod DIV
   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   assign obs = {sync_300Hz, mode, cs, busy, cmd_ready,
                 done, wdog_trip, fixed_value};

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst_l = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      e_mode = 1'b0;
      e_cs   = 1'b0;
      e_val  = RST_V;
   endtask

   task automatic offer(input logic [1:0] op, input logic [15:0] val,
                        input int phase, input int rnd_wait);
      int n;
      repeat (rnd_wait) @(negedge clk);
      n = 0;
      while (phase >= 0 && (cyc % DIVT) != phase && n < 2 * DIVT) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_at_offer cyc=%0d got %b want 1",
                  cyc, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_value = val;
      acc_cyc   = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_value = 16'($urandom);
   endtask

   // Expected timeline derived from the apply point (div_cnt == DIV-2)
   task automatic apply_cmd(input logic [1:0] op, input logic [15:0] val,
                            input int phase, input int rnd_wait);
      int a, o, done_t, busy_end;
      logic n_mode, n_cs, upd;
      logic [15:0] n_val;
      offer(op, val, phase, rnd_wait);
      a = acc_cyc + 1;
      while ((a % DIVT) != DIVT - 2) a++;
      o = a + 1;
      n_mode = e_mode;
      n_cs   = e_cs;
      n_val  = e_val;
      done_t   = o;
      busy_end = a;
      case (op)
         2'b00: begin n_mode = 1'b0; n_cs = 1'b1; n_val = val; end
         2'b01: begin
            n_mode = 1'b1; n_cs = 1'b1; n_val = val;
            done_t = o + DIVT * (RAMP_N - 1);
            busy_end = done_t;
         end
         2'b10: begin n_mode = 1'b0; n_cs = 1'b0; n_val = RST_V; end
         default: done_t = a;
      endcase
      for (int t = acc_cyc + 1; t <= busy_end + 1; t++) begin
         upd = (t >= o) && (op != 2'b11);
         exp_v = {(t % DIVT) == DIVT - 1,
                  upd ? n_mode : e_mode,
                  upd ? n_cs : e_cs,
                  t <= busy_end, t > busy_end, t == done_t, 1'b0,
                  upd ? n_val : e_val};
         checks++;
         if (obs !== exp_v || cyc != t) begin
            errors++;
            $display("FAIL op%0d cyc=%0d got %h want %h",
                     op, cyc, obs, exp_v);
         end
         if (t <= busy_end && $urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            cmd_value = 16'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      e_mode = n_mode;
      e_cs   = n_cs;
      e_val  = n_val;
      settle_cyc = busy_end + 1;
   endtask

   task automatic test_reset();
      cmd_valid = 1'b0;
      rst_l = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== {6'b000010, 1'b0, RST_V}) begin
         errors++;
         $display("FAIL reset_state got %h want %h",
                  obs, {6'b000010, 1'b0, RST_V});
      end
      do_reset();
      for (int i = 0; i < 30; i++) begin
         exp_v = {(i % DIVT) == DIVT - 1, 5'b00010, 1'b0, RST_V};
         checks++;
         if (obs !== exp_v || cyc != i) begin
            errors++;
            $display("FAIL idle_run cyc=%0d got %h want %h",
                     cyc, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_fixed();
      do_reset();
      apply_cmd(2'b00, 16'h1234, 2, 0);
   endtask

   task automatic test_ramp();
      apply_cmd(2'b01, 16'hFFFF, -1, $urandom_range(0, 9));
   endtask

   task automatic test_apply_point();
      apply_cmd(2'b00, 16'($urandom), DIVT - 2, 0);
   endtask

   task automatic test_off();
      apply_cmd(2'b00, 16'($urandom), -1, 0);
      apply_cmd(2'b10, 16'($urandom), -1, $urandom_range(0, 9));
   endtask

   task automatic test_reserved();
      apply_cmd(2'b11, 16'($urandom), -1, 0);
      apply_cmd(2'b00, 16'($urandom), -1, 0);
      apply_cmd(2'b11, 16'($urandom), -1, $urandom_range(0, 9));
   endtask

   task automatic test_random();
      for (int i = 0; i < 15; i++) begin
         apply_cmd(2'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? DIVT - 2 : -1,
                   $urandom_range(0, 9));
      end
   endtask

   task automatic test_reset_midramp();
      offer(2'b01, 16'($urandom), -1, 0);
      repeat (20) @(negedge clk);
      rst_l = 1'b0;
      #1;
      checks++;
      if (obs !== {6'b000010, 1'b0, RST_V}) begin
         errors++;
         $display("FAIL reset_midramp got %h want %h",
                  obs, {6'b000010, 1'b0, RST_V});
      end
      @(negedge clk);
      rst_l = 1'b1;
      e_mode = 1'b0;
      e_cs   = 1'b0;
      e_val  = RST_V;
      for (int i = 0; i < 15; i++) begin
         exp_v = {(i % DIVT) == DIVT - 1, 5'b00010, 1'b0, RST_V};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL post_reset cyc=%0d got %h want %h",
                     cyc, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   // Idle in HOLD: trips after WDOG_N strobes only when enabled
   task automatic test_watchdog();
      int t;
      logic tr;
      apply_cmd(2'b00, 16'h8000, -1, 0);
      for (int k = 0; k < 12 + DIVT * WDOG_N; k++) begin
         t = cyc;
         tr = WD && (t >= settle_cyc + DIVT * WDOG_N);
         exp_v = {(t % DIVT) == DIVT - 1,
                  tr ? 1'b0 : e_mode, e_cs, 3'b010, tr,
                  tr ? SAFE_V : e_val};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL watchdog cyc=%0d got %h want %h",
                     cyc, obs, exp_v);
         end
         @(negedge clk);
      end
      if (WD) begin
         e_mode = 1'b0;
         e_val  = SAFE_V;
      end
      apply_cmd(2'b00, 16'($urandom), -1, $urandom_range(0, 3));
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_ramp();
      test_apply_point();
      test_off();
      test_reserved();
      test_random();
      test_reset_midramp();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_update_ctrl.md
# dac_update_ctrl

Command sequencer sitting directly upstream of the DAC045A driver. Generates the periodic DAC update strobe and accepts setpoint commands over a valid/ready handshake. Presents `mode`, `fixed_value` and `cs` to the driver, changing them only at a fixed point before each strobe so an SPI frame never samples a moving value. Reports busy and completion status to the host register block.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `UPDATE_HZ`, 300, strobe rate; `DIV = CLK_HZ/UPDATE_HZ`, must be ≥ 4.
- `RAMP_STROBES`, 256, strobes a ramp command is held in RAMP before completion.
- `RESET_VALUE`, 16'h0000, `fixed_value` after reset and after OFF.
- `WDOG_STROBES`, 3000, idle strobes in HOLD before watchdog trip (10 s at 300 Hz).
- `SAFE_VALUE`, 16'h0000, value forced on watchdog trip.

Ports:
- `clk` in 1: system clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 00 FIXED, 01 RAMP, 10 OFF, 11 reserved.
- `cmd_value` in 16: setpoint (FIXED) or ramp limit (RAMP); ignored for OFF.
- `sync_300Hz` out 1: one-cycle update strobe to the driver.
- `mode` out 1: 0 fixed, 1 ramp.
- `fixed_value` out 16: setpoint / ramp limit.
- `cs` out 1: DAC enable.
- `busy` out 1: high in ARM and RAMP.
- `done` out 1: one-cycle completion pulse.
- `wdog_trip` out 1: sticky watchdog flag.

## Operation
- Divider `div_cnt` counts 0..DIV-1 and wraps. `sync_300Hz` is high when `div_cnt == DIV-1`. The apply point is `div_cnt == DIV-2`.
- States: IDLE, ARM, RAMP, HOLD.
- IDLE: `cs=0`, `cmd_ready=1`. An accepted command is latched and the block moves to ARM.
- ARM: `cmd_ready=0`. At the apply point, the latched command drives the outputs:
  - FIXED: `mode=0`, `fixed_value=cmd_value`, `cs=1`, then HOLD.
  - RAMP: `mode=1`, `fixed_value=cmd_value`, `cs=1`, clear the strobe counter, then RAMP.
  - OFF: `cs=0`, `mode=0`, `fixed_value=RESET_VALUE`, then IDLE.
  - Reserved op: outputs unchanged; return to the previous settled state (IDLE or HOLD).
- `done` pulses on the first `sync_300Hz` after a FIXED or OFF apply, and on the reserved-op apply cycle.
- RAMP: `cmd_ready=0`. Count strobes. On strobe number RAMP_STROBES, pulse `done` and go to HOLD with `mode` kept at 1.
- HOLD: `cmd_ready=1`, outputs stable. An accepted command goes to ARM.
- Counters: ramp and watchdog counters are 16 bits and saturate; they never wrap.

## Timing
- Reset values:
  - `div_cnt=0`, `sync_300Hz=0`, `mode=0`, `fixed_value=RESET_VALUE`, `cs=0`.
  - `cmd_ready=1`, `busy=0`, `done=0`, `wdog_trip=0`, state IDLE.
- Outputs are registered and change only on the cycle after the apply point. They are therefore stable for one full cycle before and during `sync_300Hz`.
- Command-to-output latency: from 1 to DIV cycles after acceptance.
- A command accepted on the apply-point cycle itself is applied at the next apply point, DIV cycles later.
- `cmd_valid` may drop without acceptance. `cmd_op` and `cmd_value` are sampled only on the handshake cycle.
- Reset asserted mid-ramp or in ARM returns every output to its reset value immediately. Any latched command is discarded.

## Configuration
- `DAC_UPD_WATCHDOG_EN` defined:
  - In HOLD, count strobes since the last accepted command.
  - At WDOG_STROBES, the next apply point forces `mode=0`, `fixed_value=SAFE_VALUE`, with `cs` kept at 1, and sets `wdog_trip`.
  - `wdog_trip` clears on the next accepted command.
- `DAC_UPD_WATCHDOG_EN` undefined: no watchdog counter; `wdog_trip` is tied to 0 and the port remains present.

## Structure
- Package `dac_upd_pkg` holds:
  - the `cmd_op` enum (OP_FIXED, OP_RAMP, OP_OFF, OP_RSVD);
  - the state enum;
  - the 16-bit data width constant.
- Sub-module `dac_upd_strobe_gen` (parameters CLK_HZ and UPDATE_HZ) produces `sync_300Hz` and the apply-point pulse.
- The FSM, command latch and counters live in the top module.

## Test plan
All scenarios use CLK_HZ=3000, UPDATE_HZ=300 (DIV=10), RAMP_STROBES=4 and WDOG_STROBES=5.
- Reset, then run 30 cycles: `sync_300Hz` pulses at cycles 9, 19 and 29; `cs=0`; `fixed_value=0`.
- FIXED 16'h1234 accepted at cycle 2: outputs change at cycle 9 (`cs=1`, `mode=0`, `fixed_value=1234`); `done` pulses at 9; state is HOLD.
- RAMP 16'hFFFF: `mode=1`; `busy` stays high through 4 strobes; `done` coincides with the 4th strobe; `cmd_ready` is low throughout RAMP.
- Command accepted exactly at `div_cnt=8`: applied at the following apply point, 10 cycles later.
- OFF while in HOLD: `cs=0` and `fixed_value=RESET_VALUE` after the apply point; returns to IDLE.
- With the watchdog enabled, FIXED 16'h8000 then 5 strobes with no command: `fixed_value=0`, `wdog_trip=1`; the next command clears `wdog_trip`.
